// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command target.
//   SPI_ADDR_WIDTH  : bus address width (A16..A0)
//   CMD_READ_BIT    : command-byte bit selecting read (1) or write (0)
//   CMD_A16_BIT     : command-byte bit carrying address bit 16
//   spi_cmd_state_t : transaction decode states
package spi_cmd_pkg;

    localparam int unsigned SPI_ADDR_WIDTH = 17;
    localparam int unsigned CMD_READ_BIT   = 7;
    localparam int unsigned CMD_A16_BIT    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WR_DATA,
        ST_RD_TURN,
        ST_RD_DATA
    } spi_cmd_state_t;

endpackage

// File: rtl/spi_target_shift.sv
// SPI mode-0 target bit engine: synchronizes the pad signals into clk_i,
// detects SCK/CS edges, assembles MOSI bytes and shifts MISO bytes out.
//   clk_i, reset_i : system clock, synchronous active-high reset
//   sck_i, cs_ni, rx_i : asynchronous SPI pad inputs
//   tx_o           : MISO (MSB of the tx shifter)
//   tx_byte_i      : byte loaded into the tx shifter at each byte boundary
//   byte_valid_o   : one-cycle pulse, rx_byte_o holds the completed byte
//   tx_load_o      : one-cycle pulse, a byte boundary load just happened
//   cs_active_o    : synchronized /CS is low
//   cs_fall_o      : one-cycle pulse on synchronized /CS falling edge
module spi_target_shift
    import spi_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sck_i,
    input  logic       cs_ni,
    input  logic       rx_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_o,
    output logic       byte_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       tx_load_o,
    output logic       cs_active_o,
    output logic       cs_fall_o
);

    // [0],[1] synchronizer stages, [2] previous value for edge detection
    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] rx_q;

    logic       armed_q;
    logic       pend_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_sr_q;
    logic [7:0] tx_sr_q;
    logic [7:0] rx_byte_q;
    logic       byte_valid_q;
    logic       tx_load_q;
    logic       cs_fall_q;

    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic [7:0] rx_shifted;

    assign sck_rise   = sck_q[1] & ~sck_q[2];
    assign sck_fall   = ~sck_q[1] & sck_q[2];
    assign cs_fall    = cs_q[2] & ~cs_q[1];
    assign rx_shifted = {rx_sr_q[6:0], rx_q[1]};

    // /CS syncs reset low so that a /CS held low across reset never looks
    // like a fresh falling edge; a new transaction needs /CS high first.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sck_q        <= '0;
            cs_q         <= '0;
            rx_q         <= '0;
            armed_q      <= 1'b0;
            pend_q       <= 1'b0;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            tx_load_q    <= 1'b0;
            cs_fall_q    <= 1'b0;
        end else begin
            sck_q        <= {sck_q[1:0], sck_i};
            cs_q         <= {cs_q[1:0], cs_ni};
            rx_q         <= {rx_q[0], rx_i};
            byte_valid_q <= 1'b0;
            tx_load_q    <= 1'b0;
            cs_fall_q    <= cs_fall;

            if (!armed_q || cs_q[1]) begin
                // Idle or /CS high: drop any partial byte, MISO shifter = 0x00
                armed_q   <= cs_fall;
                pend_q    <= 1'b0;
                bit_cnt_q <= '0;
                rx_sr_q   <= '0;
                tx_sr_q   <= '0;
            end else begin
                if (sck_rise) begin
                    rx_sr_q   <= rx_shifted;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_q    <= rx_shifted;
                        byte_valid_q <= 1'b1;
                        pend_q       <= 1'b1;
                    end
                end
                // First falling edge after a completed byte is the boundary
                if (sck_fall) begin
                    if (pend_q) begin
                        tx_sr_q   <= tx_byte_i;
                        pend_q    <= 1'b0;
                        tx_load_q <= 1'b1;
                    end else begin
                        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign tx_o         = tx_sr_q[7];
    assign byte_valid_o = byte_valid_q;
    assign rx_byte_o    = rx_byte_q;
    assign tx_load_o    = tx_load_q;
    assign cs_active_o  = ~cs_q[1];
    assign cs_fall_o    = cs_fall_q;

endmodule

// File: rtl/spi_cmd_target.sv
// SPI command target: decodes CMD / ADDR_HI / ADDR_LO / data bytes into
// single-byte bus read/write requests with auto-incrementing address.
//   clk_sys_i, reset_i          : system clock, synchronous active-high reset
//   spi_sck_i, spi_cs_ni,
//   spi_rx_i, spi_tx_o          : SPI mode-0 pads
//   addr_o, data_o, we_o, req_o : bus request, held until ack_i
//   ack_i, data_i               : bus completion pulse and read data
//   err_o                       : sticky overrun / timeout flag
module spi_cmd_target
    import spi_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = SPI_ADDR_WIDTH,
    parameter int unsigned ACK_TIMEOUT = 12
) (
    input  logic                  clk_sys_i,
    input  logic                  reset_i,
    input  logic                  spi_sck_i,
    input  logic                  spi_cs_ni,
    input  logic                  spi_rx_i,
    output logic                  spi_tx_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [7:0]            data_o,
    output logic                  we_o,
    output logic                  req_o,
    input  logic                  ack_i,
    input  logic [7:0]            data_i,
    output logic                  err_o
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       tx_load;
    logic       cs_active;
    logic       cs_fall;
    logic [7:0] tx_byte_c;

    spi_cmd_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH-1:0] addr_full;
    logic [7:0]            data_q, data_d;
    logic                  we_q, we_d;
    logic                  req_q, req_d;
    logic                  err_q, err_d;
    logic [7:0]            hold_q, hold_d;
    logic                  rd_q, rd_d;
    logic                  a16_q, a16_d;
    logic [7:0]            ahi_q, ahi_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    spi_target_shift u_shift (
        .clk_i        (clk_sys_i),
        .reset_i      (reset_i),
        .sck_i        (spi_sck_i),
        .cs_ni        (spi_cs_ni),
        .rx_i         (spi_rx_i),
        .tx_byte_i    (tx_byte_c),
        .tx_o         (spi_tx_o),
        .byte_valid_o (byte_valid),
        .rx_byte_o    (rx_byte),
        .tx_load_o    (tx_load),
        .cs_active_o  (cs_active),
        .cs_fall_o    (cs_fall)
    );

    // Outside RD_DATA every boundary (command, address, dummy) sends 0x00
    assign tx_byte_c = (state_q == ST_RD_DATA) ? hold_q : 8'h00;
    assign addr_next = ADDR_WIDTH'(addr_q + ADDR_WIDTH'(1));
    assign addr_full = ADDR_WIDTH'({a16_q, ahi_q, rx_byte});

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            req_addr_q <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= '0;
            rd_q       <= 1'b0;
            a16_q      <= 1'b0;
            ahi_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_addr_q <= req_addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            req_q      <= req_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            rd_q       <= rd_d;
            a16_q      <= a16_d;
            ahi_q      <= ahi_d;
            tmo_q      <= tmo_d;
        end
    end

    // Decode FSM, request handshake, overrun and timeout detection
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        req_addr_d = req_addr_q;
        data_d     = data_q;
        we_d       = we_q;
        req_d      = req_q;
        err_d      = err_q;
        hold_d     = hold_q;
        rd_d       = rd_q;
        a16_d      = a16_q;
        ahi_d      = ahi_q;
        tmo_d      = '0;

        // Outstanding request: completes on ack, never cancelled by /CS
        if (req_q) begin
            tmo_d = tmo_q;
            if (ack_i) begin
                req_d = 1'b0;
                if (!we_q) begin
                    hold_d = data_i;
                end
            end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                err_d = 1'b1;
            end else begin
                tmo_d = TMO_W'(tmo_q + TMO_W'(1));
            end
        end

        // /CS high overrides any byte completing in the same cycle
        if (!cs_active) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_valid) begin
                        rd_d    = rx_byte[CMD_READ_BIT];
                        a16_d   = rx_byte[CMD_A16_BIT];
                        state_d = ST_ADDR_HI;
                    end
                end
                ST_ADDR_HI: begin
                    if (byte_valid) begin
                        ahi_d   = rx_byte;
                        state_d = ST_ADDR_LO;
                    end
                end
                ST_ADDR_LO: begin
                    if (byte_valid) begin
                        addr_d = addr_full;
                        if (rd_q) begin
                            state_d = ST_RD_TURN;
                            if (req_q) begin
                                err_d = 1'b1;
                            end else begin
                                req_d      = 1'b1;
                                we_d       = 1'b0;
                                req_addr_d = addr_full;
                            end
                        end else begin
                            state_d = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (byte_valid) begin
                        if (req_q) begin
                            err_d = 1'b1;
                        end else begin
                            req_d      = 1'b1;
                            we_d       = 1'b1;
                            data_d     = rx_byte;
                            req_addr_d = addr_q;
                            addr_d     = addr_next;
                        end
                    end
                end
                ST_RD_TURN: begin
                    if (byte_valid) begin
                        state_d = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    // Holding data already went to the shifter; prefetch next
                    if (tx_load) begin
                        if (req_q) begin
                            err_d = 1'b1;
                        end else begin
                            req_d      = 1'b1;
                            we_d       = 1'b0;
                            req_addr_d = addr_next;
                            addr_d     = addr_next;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign addr_o = req_addr_q;
    assign data_o = data_q;
    assign we_o   = we_q;
    assign req_o  = req_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_spi_cmd_target.sv
// Directed bench for spi_cmd_target: SPI mode-0 initiator driven from tasks,
// a bus responder that acks after a programmable latency and logs requests.
`timescale 1ns/1ps
module tb_spi_cmd_target;

    localparam int HALF = 120;   // SCK half period (~4 MHz SCK, 100 MHz clk)

    typedef struct packed {
        logic [16:0] addr;
        logic        we;
        logic [7:0]  data;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_tx;
    logic [16:0] addr_o;
    logic [7:0]  data_o;
    logic        we_o;
    logic        req_o;
    logic        ack_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        err_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic ack_en   = 1'b1;
    int   ack_lat  = 2;
    int   wait_cnt = 0;
    bus_t log_q[$];

    spi_cmd_target #(.ADDR_WIDTH(17), .ACK_TIMEOUT(12)) dut (
        .clk_sys_i (clk),
        .reset_i   (reset),
        .spi_sck_i (spi_sck),
        .spi_cs_ni (spi_cs_n),
        .spi_rx_i  (spi_mosi),
        .spi_tx_o  (spi_tx),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .we_o      (we_o),
        .req_o     (req_o),
        .ack_i     (ack_i),
        .data_i    (data_i),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_value(input logic [16:0] a);
        if (a == 17'h00010) return 8'h3C;
        if (a == 17'h00011) return 8'hC3;
        return a[7:0] ^ 8'h99;
    endfunction

    // Bus responder: ack ack_lat cycles after req_o is first seen high
    always @(negedge clk) begin
        if (ack_i) begin
            ack_i = 1'b0;
        end else if (req_o && ack_en) begin
            if (wait_cnt >= ack_lat - 1) begin
                data_i   = we_o ? 8'h00 : rd_value(addr_o);
                log_q.push_back({addr_o, we_o, we_o ? data_o : data_i});
                ack_i    = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else if (!req_o) begin
            wait_cnt = 0;
        end
    end

    task automatic spi_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        spi_mosi = 1'b0;
        #(HALF);
    endtask

    task automatic spi_end();
        #(HALF);
        spi_cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mosi[i];
            #(HALF);
            miso[i] = spi_tx;
            spi_sck = 1'b1;
            #(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] junk;
        spi_bits(b, 8, junk);
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", req_o); end
        n_checks++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we_o); end
        n_checks++; if (addr_o !== 17'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr_o); end
        n_checks++; if (data_o !== 8'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
        n_checks++; if (spi_tx !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", spi_tx); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write();
        bus_t e;
        log_q.delete();
        spi_begin();
        send(8'h00); send(8'h80); send(8'h00); send(8'hA5);
        spi_end();
        settle();
        e = (log_q.size() > 0) ? log_q[0] : '0;
        n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL write_count got %0d want 1", log_q.size()); end
        n_checks++; if (e.addr !== 17'h08000) begin n_fail++; $display("FAIL write_addr got %h want 08000", e.addr); end
        n_checks++; if (e.we !== 1'b1) begin n_fail++; $display("FAIL write_we got %b want 1", e.we); end
        n_checks++; if (e.data !== 8'hA5) begin n_fail++; $display("FAIL write_data got %h want a5", e.data); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL write_err got %b want 0", err_o); end
    endtask

    task automatic test_burst_wrap();
        bus_t e0, e1;
        log_q.delete();
        spi_begin();
        send(8'h01); send(8'hFF); send(8'hFF); send(8'h11); send(8'h22);
        spi_end();
        settle();
        e0 = (log_q.size() > 0) ? log_q[0] : '0;
        e1 = (log_q.size() > 1) ? log_q[1] : '0;
        n_checks++; if (log_q.size() != 2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", log_q.size()); end
        n_checks++; if (e0 !== {17'h1FFFF, 1'b1, 8'h11}) begin n_fail++; $display("FAIL wrap_first got %h/%b/%h want 1ffff/1/11", e0.addr, e0.we, e0.data); end
        n_checks++; if (e1 !== {17'h00000, 1'b1, 8'h22}) begin n_fail++; $display("FAIL wrap_second got %h/%b/%h want 00000/1/22", e1.addr, e1.we, e1.data); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b want 0", err_o); end
    endtask

    task automatic test_read_burst();
        logic [7:0] m [6];
        logic [7:0] tx [6];
        logic [16:0] want_addr [3];
        bus_t e;
        tx = '{8'h80, 8'h00, 8'h10, 8'h00, 8'hFF, 8'hFF};
        want_addr = '{17'h00010, 17'h00011, 17'h00012};
        log_q.delete();
        spi_begin();
        for (int i = 0; i < 6; i++) spi_bits(tx[i], 8, m[i]);
        spi_end();
        settle();
        n_checks++; if (m[2] !== 8'h00) begin n_fail++; $display("FAIL rd_addr_miso got %h want 00", m[2]); end
        n_checks++; if (m[3] !== 8'h00) begin n_fail++; $display("FAIL rd_dummy_miso got %h want 00", m[3]); end
        n_checks++; if (m[4] !== 8'h3C) begin n_fail++; $display("FAIL rd_byte0_miso got %h want 3c", m[4]); end
        n_checks++; if (m[5] !== 8'hC3) begin n_fail++; $display("FAIL rd_byte1_miso got %h want c3", m[5]); end
        n_checks++; if (log_q.size() < 3) begin n_fail++; $display("FAIL rd_count got %0d want >=3", log_q.size()); end
        for (int i = 0; i < 3; i++) begin
            e = (log_q.size() > i) ? log_q[i] : '0;
            n_checks++;
            if (e.addr !== want_addr[i] || e.we !== 1'b0) begin
                n_fail++; $display("FAIL rd_req%0d got %h/we%b want %h/we0", i, e.addr, e.we, want_addr[i]);
            end
        end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b want 0", err_o); end
    endtask

    task automatic test_abort();
        logic [7:0] junk;
        bus_t e;
        log_q.delete();
        spi_begin();
        send(8'h00);
        spi_bits(8'h80, 4, junk);
        spi_end();
        settle();
        n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL abort_count got %0d want 0", log_q.size()); end
        n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL abort_req got %b want 0", req_o); end
        spi_begin();
        send(8'h00); send(8'h00); send(8'h05); send(8'h7E);
        spi_end();
        settle();
        e = (log_q.size() > 0) ? log_q[0] : '0;
        n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL abort_next_count got %0d want 1", log_q.size()); end
        n_checks++; if (e !== {17'h00005, 1'b1, 8'h7E}) begin n_fail++; $display("FAIL abort_next got %h/%b/%h want 00005/1/7e", e.addr, e.we, e.data); end
    endtask

    task automatic test_overrun();
        bus_t e;
        log_q.delete();
        ack_en = 1'b0;
        spi_begin();
        send(8'h00); send(8'h01); send(8'h00); send(8'h44); send(8'h55);
        repeat (10) @(negedge clk);
        n_checks++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL ovr_req got %b want 1", req_o); end
        n_checks++; if (addr_o !== 17'h00100) begin n_fail++; $display("FAIL ovr_addr got %h want 00100", addr_o); end
        n_checks++; if (data_o !== 8'h44) begin n_fail++; $display("FAIL ovr_data got %h want 44", data_o); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ovr_err got %b want 1", err_o); end
        spi_end();
        ack_en = 1'b1;
        settle();
        e = (log_q.size() > 0) ? log_q[0] : '0;
        n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL ovr_count got %0d want 1", log_q.size()); end
        n_checks++; if (e !== {17'h00100, 1'b1, 8'h44}) begin n_fail++; $display("FAIL ovr_entry got %h/%b/%h want 00100/1/44", e.addr, e.we, e.data); end
        n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL ovr_req_done got %b want 0", req_o); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ovr_err_sticky got %b want 1", err_o); end
    endtask

    task automatic test_reset_mid();
        bus_t e;
        log_q.delete();
        ack_en = 1'b0;
        spi_begin();
        send(8'h00); send(8'h02); send(8'h00); send(8'h66);
        for (int i = 0; i < 50 && req_o !== 1'b1; i++) @(negedge clk);
        repeat (15) @(negedge clk);
        n_checks++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_req got %b want 1", req_o); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_err got %b want 1", err_o); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL mid_req got %b want 0", req_o); end
        n_checks++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL mid_we got %b want 0", we_o); end
        n_checks++; if (addr_o !== 17'h0) begin n_fail++; $display("FAIL mid_addr got %h want 0", addr_o); end
        n_checks++; if (data_o !== 8'h0) begin n_fail++; $display("FAIL mid_data got %h want 0", data_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL mid_err got %b want 0", err_o); end
        reset = 1'b0;
        ack_en = 1'b1;
        // /CS still low: this byte must not be decoded
        send(8'h77);
        spi_end();
        settle();
        n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL mid_stray_count got %0d want 0", log_q.size()); end
        spi_begin();
        send(8'h00); send(8'h00); send(8'h33); send(8'h9C);
        spi_end();
        settle();
        e = (log_q.size() > 0) ? log_q[0] : '0;
        n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL mid_next_count got %0d want 1", log_q.size()); end
        n_checks++; if (e !== {17'h00033, 1'b1, 8'h9C}) begin n_fail++; $display("FAIL mid_next got %h/%b/%h want 00033/1/9c", e.addr, e.we, e.data); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL mid_next_err got %b want 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_burst_wrap();
        test_read_burst();
        test_abort();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_cmd_target.md
# spi_cmd_target

FPGA-side SPI target that decodes the command/address/data stream the MCU sends over SPI and turns it into single-byte read and write requests on the internal bus, with automatic address increment for bursts. It sits between the pad-level SPI pins (SCK, /CS, MOSI, MISO) and the bus arbiter. It is the responder counterpart to the MCU's SPI initiator. It uses SPI mode 0 and MSB-first bytes.

## Interface
- `ADDR_WIDTH`, 17: bus address width (A16..A0).
- `ACK_TIMEOUT`, 12: number of `clk_sys_i` cycles after `req_o` within which `ack_i` must arrive.

Ports:
- `clk_sys_i` in 1: system clock; sole clock domain. Must be at least 4× SCK.
- `reset_i` in 1: synchronous, active-high reset.
- `spi_sck_i` in 1: SPI clock, asynchronous.
- `spi_cs_ni` in 1: SPI chip select, active low, asynchronous.
- `spi_rx_i` in 1: MOSI, asynchronous.
- `spi_tx_o` out 1: MISO.
- `addr_o` out ADDR_WIDTH: bus address of the current request.
- `data_o` out 8: write data.
- `we_o` out 1: 1 = write request, 0 = read request; qualified by `req_o`.
- `req_o` out 1: request; held high until `ack_i`.
- `ack_i` in 1: one-cycle completion pulse; read data is valid with it.
- `data_i` in 8: read data.
- `err_o` out 1: sticky error flag (overrun or timeout); cleared only by reset.

## Operation
- `spi_sck_i`, `spi_cs_ni` and `spi_rx_i` pass through 2-flop synchronizers, then edge detection.
- MOSI is sampled on SCK rising edges. MISO shifts on SCK falling edges.
- A byte is complete on the 8th rising edge after /CS falls. Completion raises a one-cycle `byte_valid`.
- Transaction byte 0 is the command:
  - bit7 = R (1 = read).
  - bit0 = A16.
  - bits 6..1 are ignored.
- Bytes 1 and 2 are A15..8 and A7..0.
- FSM states: IDLE → CMD → ADDR_HI → ADDR_LO → then WR_DATA or RD_TURN, then RD_DATA. All states except IDLE hold /CS low.
- IDLE: /CS falling moves to CMD. MISO tx register is loaded with 0x00.
- WR_DATA: each received byte issues a request with `we_o`=1, `data_o`=byte, `addr_o`=addr. Addr then increments.
- RD_TURN:
  - On ADDR_LO completion, a read request is issued for addr.
  - The next byte is a dummy; MISO = 0x00 during it.
  - On `ack_i`, `data_i` is latched into the holding register.
- RD_DATA: at each byte boundary (first SCK falling edge after `byte_valid`):
  - The holding register loads the tx shifter.
  - addr increments.
  - A read of the new addr is issued.
  - Bytes received on MOSI are ignored.
- Address arithmetic is modulo 2^17: 0x1FFFF + 1 = 0x00000.
- Overrun: if `byte_valid` requires a new request while `req_o` is still high, the byte is dropped and `err_o` is set. Addr does not increment.
- Timeout: if `ack_i` has not arrived by the next RD_DATA load, stale holding data is shifted out and `err_o` is set.
- /CS rising in any state:
  - FSM returns to IDLE and the partial byte is discarded.
  - An outstanding `req_o` stays high until `ack_i`; bus cycles are never cancelled.
  - No new request is issued.
- `ack_i` while `req_o` = 0 is ignored.

## Timing
- Reset values: `req_o`=0, `we_o`=0, `addr_o`=0, `data_o`=0, `err_o`=0, `spi_tx_o`=0, FSM=IDLE, shifters=0.
- Reset mid-transfer: everything clears in the same cycle. The block waits for /CS high before it accepts a new CMD.
- `byte_valid` asserts 3 `clk_sys_i` cycles after the SCK rising edge (2 synchronizer cycles + 1 edge-detect cycle).
- `req_o` rises on the cycle after `byte_valid`. `addr_o`, `data_o` and `we_o` are stable from that cycle until `ack_i`.
- `req_o` falls on the cycle after `ack_i`. The minimum request is 1 cycle.
- MISO MSB is valid within 3 cycles of the SCK falling edge at a byte boundary, or of the /CS falling edge.
- Simultaneous /CS rise and `byte_valid`: /CS wins; no request is issued.

## Structure
- Package `spi_cmd_pkg` holds:
  - The state enum `spi_cmd_state_t`.
  - `CMD_READ_BIT` = 7 and `CMD_A16_BIT` = 0.
  - `SPI_ADDR_WIDTH` = 17.
- Sub-module `spi_target_shift` contains:
  - The synchronizers and edge detection.
  - The rx and tx shift registers and the bit counter.
  - Outputs `byte_valid_o` and `rx_byte_o`, and input `tx_byte_i`, loaded at byte boundaries.
- The top level holds the FSM, address counter, request handshake and error logic.

## Test plan
- Write: 0x00 0x80 0x00 0xA5 at 4 MHz SCK, ack 2 cycles later → one request with `addr_o`=0x08000, `we_o`=1, `data_o`=0xA5; `err_o`=0.
- Burst wrap: 0x01 0xFF 0xFF 0x11 0x22 → writes 0x1FFFF=0x11, then 0x00000=0x22.
- Read burst: 0x80 0x00 0x10, dummy, then 2 bytes; bus returns 0x3C @0x00010 and 0xC3 @0x00011 → MISO bytes 0x00 (dummy), 0x3C, 0xC3. A trailing read of 0x00012 is issued.
- Abort: /CS rises after 4 bits of ADDR_HI → no request. The following write 0x00 0x00 0x05 0x7E produces a write of 0x7E at 0x00005.
- Overrun: `ack_i` withheld across two write data bytes → second byte is dropped, `err_o`=1, and a single request remains pending until ack.
- Reset while `req_o`=1 mid-burst → all outputs return to reset values on the next cycle. The next transaction decodes correctly.
